// File: rtl/matmul_engine.sv
// N x N weight-stationary matrix-multiply engine: byte-serial operand loads, skewed
// systolic accumulation, row-major result readout. Optional macro: SATURATE_EN.
module matmul_engine #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] ui_in,
  output logic              busy,
  output logic              cmd_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] uo_out,
  output logic              done
);

  localparam int unsigned NN        = N * N;
  localparam int unsigned IDX_W     = $clog2(NN);
  localparam int unsigned ACC_W     = 2 * DATA_W + $clog2(N);
  localparam int unsigned CNT_W     = $clog2(NN + 3 * N);
  localparam int unsigned COMP_LAST = 3 * N - 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  wptr_q, wptr_d, aptr_q, aptr_d;
  logic [DATA_W-1:0] w_q [NN];
  logic [DATA_W-1:0] w_d [NN];
  logic [DATA_W-1:0] a_q [NN];
  logic [DATA_W-1:0] a_d [NN];
  logic [ACC_W-1:0]  acc_q [NN];
  logic [ACC_W-1:0]  acc_d [NN];
  logic              busy_q, busy_d, err_q, err_d, ov_q, ov_d, done_q, done_d;
  logic [DATA_W-1:0] uo_q, uo_d;
  logic              accept;
  int                kk;

  function automatic logic [DATA_W-1:0] narrow(input logic [ACC_W-1:0] v);
`ifdef SATURATE_EN
    return (v > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Next-state: command decode, skewed MAC sequencing, readout selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    aptr_d  = aptr_q;
    w_d     = w_q;
    a_d     = a_q;
    acc_d   = acc_q;
    ov_d    = 1'b0;
    uo_d    = '0;
    done_d  = 1'b0;
    kk      = 0;
    accept  = cmd_valid && (state_q == S_IDLE);
    err_d   = cmd_valid && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            2'b00: begin
              wptr_d = '0;
              aptr_d = '0;
            end
            2'b01: begin
              w_d[wptr_q] = ui_in;
              wptr_d = (wptr_q == IDX_W'(NN - 1)) ? '0 : wptr_q + 1'b1;
            end
            2'b10: begin
              a_d[aptr_q] = ui_in;
              aptr_d = (aptr_q == IDX_W'(NN - 1)) ? '0 : aptr_q + 1'b1;
            end
            default: begin
              state_d = S_COMPUTE;
              cnt_d   = '0;
              acc_d   = '{default: '0};
            end
          endcase
        end
      end
      S_COMPUTE: begin
        // PE(i,j) sees A[i][k] and W[k][j] at step k + i + j (row/column skew)
        for (int i = 0; i < int'(N); i++) begin
          for (int j = 0; j < int'(N); j++) begin
            kk = int'(cnt_q) - i - j;
            if (kk >= 0 && kk < int'(N)) begin
              acc_d[IDX_W'(i * int'(N) + j)] = acc_q[IDX_W'(i * int'(N) + j)]
                + ACC_W'(a_q[IDX_W'(i * int'(N) + kk)]) * ACC_W'(w_q[IDX_W'(kk * int'(N) + j)]);
            end
          end
        end
        if (cnt_q == CNT_W'(COMP_LAST)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(NN - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    if (state_d == S_DRAIN) begin
      ov_d = 1'b1;
      uo_d = narrow(acc_d[cnt_d[IDX_W-1:0]]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      aptr_q  <= '0;
      w_q     <= '{default: '0};
      a_q     <= '{default: '0};
      acc_q   <= '{default: '0};
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      uo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      aptr_q  <= aptr_d;
      w_q     <= w_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      uo_q    <= uo_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign cmd_err   = err_q;
  assign out_valid = ov_q;
  assign uo_out    = uo_q;
  assign done      = done_q;

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N matrix-multiply engine that generalises the fixed 2×2 TPU datapath into one self-sequencing block. It holds a weight-stationary N×N operand store and an N×N input store, both loaded byte-serially. On a start command it computes C = A × W and streams the N×N result out one element per cycle. It is the next-generation replacement for the hard-wired 2×2 core and carries its own command decoder, operand stores, compute sequencer and readout path.

## Interface
- N, 2, matrix dimension (2..4)
- DATA_W, 8, operand and result width; unsigned
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  command strobe
- cmd  in  2  00 = clear pointers, 01 = load weight byte, 10 = load input byte, 11 = start
- ui_in  in  DATA_W  operand byte for load commands
- busy  out  1  compute or readout in progress
- cmd_err  out  1  one-cycle pulse when a command arrives while busy
- out_valid  out  1  result beat valid
- uo_out  out  DATA_W  result element
- done  out  1  one-cycle pulse after the last result beat

## Operation
- Reset (asynchronous, active-high) sets all outputs to 0 and clears both pointers, both stores, the accumulators and the FSM (state IDLE).
- A command is accepted when cmd_valid=1 and busy=0.
- cmd_valid=1 while busy=1: the command is ignored and cmd_err pulses on the next cycle.
- Stores hold N×N elements each, row-major, with index = row·N + col.
  - Load weight (01) writes ui_in to W[wptr]; wptr increments modulo N·N.
  - Load input (10) writes ui_in to A[aptr]; aptr increments modulo N·N.
  - Past N·N writes, the pointer wraps and overwrites index 0.
- Clear pointers (00): wptr=aptr=0; store contents are unchanged.
- Stores persist across runs, so weights can be reused with new inputs without reloading.
- Start (11) runs the FSM IDLE → COMPUTE → DRAIN → IDLE.
  - COMPUTE: A rows enter with a skew of row i delayed i cycles. Partial sums flow through the array. C[i][j] = Σk A[i][k]·W[k][j] is accumulated at internal width 2·DATA_W + clog2(N), with no overflow.
  - DRAIN: emits C in row-major order, one element per cycle, with out_valid=1.
- Output narrowing from accumulator width to DATA_W is set by the Configuration section.
- Stores are read-only during COMPUTE and DRAIN; no load can be accepted while busy.
- Reset mid-run aborts immediately. No done pulse is issued, and stores are cleared.

## Timing
- Start accepted at edge T:
  - busy=1 from T+1.
  - COMPUTE occupies cycles T+1 … T+3N−1 (3N−1 cycles) for every N.
- DRAIN occupies the next N·N cycles:
  - out_valid=1 and uo_out = C[k], k = 0 … N·N−1.
  - uo_out is registered.
  - When out_valid=0, uo_out is 0.
- Cycle after the last beat: done=1 for one cycle, busy=0 in that same cycle, and the FSM is in IDLE.
  - A command presented in the done cycle is accepted.
- Total start-to-done latency: 3N−1 + N·N + 1 cycles (N=2: 10).
- Load commands take effect on the accepting edge. A load accepted the cycle before a start is visible to that start.
- cmd_err is registered, one cycle after the rejected command.

## Configuration
- SATURATE_EN defined: each result is clamped to 2^DATA_W − 1 if the accumulator exceeds it; otherwise it passes unchanged.
- SATURATE_EN undefined: each result is the low DATA_W bits of the accumulator (modulo wrap).

## Test plan
- N=2, W=[1,2;3,4], A=[5,6;7,8], start → after 5 COMPUTE cycles, 4 beats 23,34,31,46; done one cycle later; busy high exactly 9 cycles.
- Reuse: after the previous run, clear pointers, load A=[1,0;0,1], start (no weight reload) → beats 1,2,3,4.
- Overflow, N=2, all W=A=255 → sum 130050 per element. With SATURATE_EN: four beats of 255. Without: four beats of 2.
- Pointer wrap: load 5 weight bytes 9,1,2,3,4 with A = identity → C = [4,1;2,3].
- Busy rejection: cmd_valid with load weight 0xFF during DRAIN → cmd_err pulses once, W is unchanged (verified by rerun), and the result stream is unaffected.
- Reset mid-COMPUTE (N=3): assert reset 2 cycles after start → busy, out_valid, done, uo_out are 0 immediately. A rerun with no loads yields nine beats of 0.
